// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Used by every file of the block through import nibble_serial_add_ctrl_pkg::*.
package nibble_serial_add_ctrl_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// The sub signal exists only when NIBBLE_SERIAL_ADD_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 16
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
`endif

endinterface

// File: rtl/nibble_serial_add_ctrl_add4_slice.sv
// 4-bit ripple-carry adder slice; the controller reuses one instance
// for every nibble of an operation.
module add4_slice
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic c;

   always_comb begin
      c = ci;
      s = '0;
      for (int unsigned i = 0; i < NIBBLE_W; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder: captures operands, adds one nibble per RUN cycle.
// Define NIBBLE_SERIAL_ADD_SUB_EN to add the sub (a - b) request.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input logic                    clk,
   input logic                    rst,
   nibble_serial_add_ctrl_if.slave bus
);

   localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
   localparam int unsigned IDX_W   = $clog2(NIBBLES);

   if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             accept;
   logic             handoff;
   logic             last;
   logic [WIDTH-1:0] b_in;
   logic             carry_in;

   logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
   logic                slice_co;

   assign accept  = (state_q == IDLE) && bus.in_valid;
   assign handoff = (state_q == DONE) && bus.out_ready;
   assign last    = (idx_q == IDX_W'(NIBBLES - 1));

   // Subtraction is a + ~b + 1, folded into the operand capture.
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
   assign b_in     = bus.sub ? ~bus.b : bus.b;
   assign carry_in = bus.sub ? 1'b1   : bus.cin;
`else
   assign b_in     = bus.b;
   assign carry_in = bus.cin;
`endif

   assign slice_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
   assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

   add4_slice u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)  state_d = RUN;
         RUN:     if (last)    state_d = DONE;
         DONE:    if (handoff) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q == RUN) || (state_q == DONE);
      bus.sum       = sum_q;
      bus.cout      = cout_q;
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      if (accept) begin
         a_d     = bus.a;
         b_d     = b_in;
         carry_d = carry_in;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_s;
         carry_d = slice_co;
         if (last) begin
            cout_d = slice_co;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a result scoreboard.
// Subtraction steps run when NIBBLE_SERIAL_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

   localparam int unsigned WIDTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [WIDTH:0] sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, scramble inputs, wait for result, hold, hand off.
   task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tci, input logic tsub, input int unsigned hold);
      int unsigned    lat;
      logic [WIDTH:0] exp;
      logic [WIDTH:0] got;
      logic [WIDTH-1:0] nb;
      check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
      bus.a = ta;
      bus.b = tb_v;
      bus.cin = tci;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
      bus.sub = tsub;
`endif
      bus.in_valid = 1'b1;
      if (tsub) begin
         nb  = ~tb_v;
         exp = {1'b0, ta} + {1'b0, nb} + (WIDTH+1)'(1);
      end else begin
         exp = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tci};
      end
      sb.push_back(exp);
      step();
      bus.in_valid = 1'b0;
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      bus.cin = ~tci;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
      bus.sub = ~tsub;
`endif
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         check("run_in_ready", {31'd0, bus.in_ready}, 32'd0);
         bus.in_valid = 1'b1;
         step();
         bus.in_valid = 1'b0;
         lat++;
      end
      check("latency", lat, 32'd4);
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         got = '0;
      end else begin
         got = sb.pop_front();
      end
      check("result", {15'd0, bus.cout, bus.sum}, {15'd0, got});
      bus.in_valid = 1'b1;
      for (int unsigned i = 0; i < hold; i++) begin
         step();
         check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("hold_result", {15'd0, bus.cout, bus.sum}, {15'd0, got});
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      check("post_valid", {31'd0, bus.out_valid}, 32'd0);
      check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("post_busy", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
      bus.sub = 1'b0;
`endif
      bus.out_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_result", {15'd0, bus.cout, bus.sum}, 32'd0);

      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 3);
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1);
      for (int k = 0; k < 4; k++) begin
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 2));
      end

      // Abort in the second RUN cycle.
      bus.a = 16'h1111;
      bus.b = 16'h2222;
      bus.cin = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("abort_result", {15'd0, bus.cout, bus.sum}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
      end
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      check("sub_lt", {15'd0, bus.cout, bus.sum}, 32'h0FFFE);
      do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1);
      check("sub_gt", {15'd0, bus.cout, bus.sum}, 32'h10002);
      do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 0);
`endif

      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NIBBLES = WIDTH/4: number of 4-bit add steps per operation.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  controller can accept operands.
REQ-008 a  input  WIDTH  addend A.
REQ-009 b  input  WIDTH  addend B.
REQ-010 cin  input  1  carry-in for the least significant nibble.
REQ-011 sub  input  1  subtract request; SHALL be present only when SUB_EN is defined (see REQ-031).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of the most significant nibble.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready the block SHALL capture a, b and cin into registers, clear nibble index idx to 0, and go to RUN.
REQ-019 RUN: each cycle the block SHALL add operand nibble idx plus the carry register using one 4-bit slice, write sum[4*idx+3:4*idx], update the carry register, and increment idx.
REQ-020 RUN SHALL go to DONE on the cycle it processes idx==NIBBLES-1; idx SHALL never exceed NIBBLES-1 (no wrap).
REQ-021 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting edge (WIDTH=16 gives 4).
REQ-022 DONE: out_valid=1; sum and cout SHALL be held stable until out_valid&out_ready, after which the state SHALL be IDLE on the next cycle.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored; no acceptance in the same cycle as a result handoff.
REQ-024 Arithmetic: {cout,sum} SHALL equal a+b+cin modulo 2^(WIDTH+1).
REQ-025 Changes to a, b and cin after acceptance SHALL NOT affect the result.

Reset
REQ-026 rst SHALL force IDLE, in_ready=1 (from the first cycle after reset), out_valid=0, busy=0, sum=0, cout=0, idx=0 and carry=0.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted operation.
REQ-028 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-029 Macro NIBBLE_SERIAL_ADD_SUB_EN SHALL enable subtraction.
REQ-030 Without the macro, the sub port SHALL be absent and behaviour SHALL follow REQ-024.
REQ-031 With the macro, sub is captured at acceptance. When sub=1, the block SHALL capture ~b and force the initial carry to 1 (cin ignored), so sum=a-b mod 2^WIDTH and cout=1 when no borrow occurred. sub=0 SHALL behave as REQ-024.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the nibble width constant 4.
REQ-033 The 4-bit ripple add SHALL be a sub-module named add4_slice (a[4], b[4], ci -> s[4], co), instantiated once and reused every RUN cycle.

Verification
REQ-034 WIDTH=16, a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept, sum=0x5555, cout=0.
REQ-035 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all nibbles).
REQ-036 a=0x00FF, b=0x0000, cin=1, out_ready low for 3 cycles -> sum=0x0100 held stable with out_valid=1; in_ready=0 throughout; IDLE one cycle after out_ready rises.
REQ-037 rst pulsed at the 2nd RUN cycle -> outputs at reset values the next cycle, no out_valid; a new request 0x0001+0x0001 then yields 0x0002.
REQ-038 With NIBBLE_SERIAL_ADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
